// File: rtl/imem_arbiter.sv
// Two-requester arbiter (round-robin or fixed priority) in front of a shared instruction ROM.
// One read in flight: accept -> READ -> HOLD; the response is held until rsp_ready, and no request is accepted while busy.
module imem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic              busy,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, HOLD = 2'd2} state_t;

  state_t state;
  logic   last_grant;
  logic   cur_id;
  logic   grant_id;
  logic   accept;

  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid)
      grant_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    else if (req1_valid)
      grant_id = 1'b1;
  end

  // Ready is gated by reset so a handshake can never slip through a reset cycle.
  assign accept     = (state == IDLE) && !reset && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      mem_addr   <= '0;
      cur_id     <= 1'b0;
      last_grant <= 1'b1;
      grant_cnt0 <= 16'd0;
      grant_cnt1 <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mem_addr   <= grant_id ? req1_addr : req0_addr;
            cur_id     <= grant_id;
            last_grant <= grant_id;
            if (!grant_id && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (grant_id && grant_cnt1 != 16'hFFFF)  grant_cnt1 <= grant_cnt1 + 16'd1;
            state <= READ;
          end
        end
        READ: begin
          rsp_data  <= mem_dout;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
